vgasync_ext: RTL and testbench

- Parametrised successor to the VDP VGA sync/timing generator.
- Generates per-pixel horizontal and vertical counters with six-region line and frame timing: active, two borders, front porch, sync, back porch.
- Adds the following to the plain sync generator:
  - pixel clock-enable;
  - configurable sync polarity;
  - active-relative col/row outputs;
  - line and frame tick pulses;
  - frame counter.
- Sits between the pixel clock domain and the VDP pixel fetch/colour pipeline.

---
 rtl/vgasync_ext.sv | 98 +++++++++
 tb/tb_vgasync_ext.sv | 122 ++++++++++++
 2 files changed

// File: rtl/vgasync_ext.sv
// vgasync_ext: parametrised VGA sync/timing generator with pixel enable, sync polarity, col/row, ticks and frame counter.
// Defining VGASYNC_EXT_IRQ_EN adds a frame interrupt (irq) cleared by irq_ack.
module vgasync_ext #(
   parameter int   HVID = 640,
   parameter int   HRB  = 8,
   parameter int   HFP  = 8,
   parameter int   HS   = 96,
   parameter int   HBP  = 40,
   parameter int   HLB  = 8,
   parameter int   VVID = 480,
   parameter int   VBB  = 8,
   parameter int   VFP  = 2,
   parameter int   VS   = 2,
   parameter int   VBP  = 25,
   parameter int   VTB  = 8,
   parameter logic HPOL = 1'b0,
   parameter logic VPOL = 1'b0,
   parameter int   HCW  = 10,
   parameter int   VCW  = 10,
   parameter int   FCW  = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           ce,
`ifdef VGASYNC_EXT_IRQ_EN
   input  logic           irq_ack,
   output logic           irq,
`endif
   output logic           hsync,
   output logic           vsync,
   output logic           vid_active,
   output logic           border_active,
   output logic [HCW-1:0] col,
   output logic [VCW-1:0] row,
   output logic           line_tick,
   output logic           frame_tick,
   output logic [FCW-1:0] frame_cnt
);
   localparam int HTOT = HVID + HRB + HFP + HS + HBP + HLB;
   localparam int VTOT = VVID + VBB + VFP + VS + VBP + VTB;
   localparam int HSS  = HVID + HRB + HFP;
   localparam int VSS  = VVID + VBB + VFP;

   logic [HCW-1:0] hcount;
   logic [VCW-1:0] vcount;
   logic [31:0]    hc, vc;
   logic           h_last, v_last, h_disp, v_disp, vid, h_sync, v_sync, f_hit;

   always_comb begin
      hc     = 32'(hcount);
      vc     = 32'(vcount);
      h_last = hc == HTOT - 1;
      v_last = vc == VTOT - 1;
      h_disp = hc < HVID + HRB || hc >= HTOT - HLB;
      v_disp = vc < VVID + VBB || vc >= VTOT - VTB;
      vid    = hc < HVID && vc < VVID;
      h_sync = hc >= HSS && hc < HSS + HS;
      v_sync = vc >= VSS && vc < VSS + VS;
      f_hit  = hc == 0 && vc == VVID;
   end

   // outputs are a registered decode of the pre-increment counter state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hcount        <= '0;
         vcount        <= '0;
         hsync         <= ~HPOL;
         vsync         <= ~VPOL;
         vid_active    <= 1'b0;
         border_active <= 1'b0;
         col           <= '0;
         row           <= '0;
         line_tick     <= 1'b0;
         frame_tick    <= 1'b0;
         frame_cnt     <= '0;
      end else if (ce) begin
         hcount        <= h_last ? '0 : hcount + 1'b1;
         if (h_last) vcount <= v_last ? '0 : vcount + 1'b1;
         hsync         <= h_sync ? HPOL : ~HPOL;
         vsync         <= v_sync ? VPOL : ~VPOL;
         vid_active    <= vid;
         border_active <= !vid && h_disp && v_disp;
         col           <= hcount;
         row           <= vcount;
         line_tick     <= h_last;
         frame_tick    <= f_hit;
         frame_cnt     <= frame_cnt + FCW'(f_hit);
      end
   end

`ifdef VGASYNC_EXT_IRQ_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) irq <= 1'b0;
      else if (ce && f_hit) irq <= 1'b1;
      else if (irq_ack) irq <= 1'b0;
   end
`endif
endmodule

// File: tb/tb_vgasync_ext.sv
// tb_vgasync_ext: randomized-ce bench for vgasync_ext against a pixel-index reference model.
module tb_vgasync_ext;
   localparam int HT  = 18;
   localparam int VT  = 16;
   localparam int FT  = HT * VT;
   localparam int FTI = 3 * HT;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ce = 1'b0;
   logic       hsync, vsync, vid_active, border_active, line_tick, frame_tick;
   logic [4:0] col;
   logic [3:0] row;
   logic [1:0] frame_cnt;
`ifdef VGASYNC_EXT_IRQ_EN
   logic       irq_ack = 1'b0;
   logic       irq;
`endif

   int   n = 0, frames = 0, total = 0, passed = 0;
   logic irq_m = 1'b0;

   vgasync_ext #(
      .HVID(5), .HRB(2), .HFP(2), .HS(3), .HBP(4), .HLB(2),
      .VVID(3), .VBB(2), .VFP(4), .VS(2), .VBP(3), .VTB(2),
      .HPOL(1'b0), .VPOL(1'b0), .HCW(5), .VCW(4), .FCW(2)
   ) dut (
      .clk(clk), .reset(reset), .ce(ce),
`ifdef VGASYNC_EXT_IRQ_EN
      .irq_ack(irq_ack), .irq(irq),
`endif
      .hsync(hsync), .vsync(vsync), .vid_active(vid_active),
      .border_active(border_active), .col(col), .row(row),
      .line_tick(line_tick), .frame_tick(frame_tick), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   // n counts enabled edges since reset; edge n decodes pixel index n mod FT
   always @(posedge clk) begin
      if (reset) begin
         logic hit;
         hit = ce && (n % FT) == FTI;
`ifdef VGASYNC_EXT_IRQ_EN
         irq_m = hit ? 1'b1 : irq_ack ? 1'b0 : irq_m;
`endif
         if (hit) frames++;
         if (ce) n++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h at n=%0d", tag, obs, exp, n);
   endtask

   task automatic check_all();
      int p, h, v;
      logic vid, border;
      logic [5:0] f;
      h = 0;
      v = 0;
      f = 6'b110000;
      if (n != 0) begin
         p = (n - 1) % FT;
         h = p % HT;
         v = p / HT;
         vid = h < 5 && v < 3;
         border = !vid && (h < 7 || h >= 16) && (v < 5 || v >= 14);
         f = {!(h >= 9 && h < 12), !(v >= 9 && v < 11), vid, border, h == 17, h == 0 && v == 3};
      end
      chk("flags", {26'b0, hsync, vsync, vid_active, border_active, line_tick, frame_tick}, {26'b0, f});
      chk("col", 32'(col), 32'(h));
      chk("row", 32'(row), 32'(v));
      chk("frame_cnt", 32'(frame_cnt), 32'(frames % 4));
`ifdef VGASYNC_EXT_IRQ_EN
      chk("irq", 32'(irq), 32'(irq_m));
`endif
   endtask

   task automatic step(input logic c);
      ce = c;
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      for (int i = 0; i < 4; i++) step(1'b1);
      reset = 1'b1;
      for (int i = 0; i < 600; i++) step(1'b1);
      for (int i = 0; i < 700; i++) step(i[0] == 1'b0);
      for (int i = 0; i < 1500; i++) begin
`ifdef VGASYNC_EXT_IRQ_EN
         irq_ack = ($urandom % 16) == 0;
`endif
         step(($urandom % 4) != 0);
      end
`ifdef VGASYNC_EXT_IRQ_EN
      irq_ack = 1'b0;
      for (int i = 0; i < 400 && (n % FT) != FTI; i++) step(1'b1);
      irq_ack = 1'b1;
      step(1'b1);
      step(1'b1);
      irq_ack = 1'b0;
`endif
      for (int i = 0; i < 400 && (n % FT) != 7 * HT + 5; i++) step(1'b1);
      chk("pre_reset_pos", {27'b0, col}, 32'd4);
      #2 reset = 1'b0;
      n = 0;
      frames = 0;
      irq_m = 1'b0;
      #1 check_all();
      step(1'b1);
      step(1'b1);
      reset = 1'b1;
      for (int i = 0; i < 700; i++) step(1'b1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
